mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Directly consumes the decoder's MDU-start, MDU-select and MF-select controls plus the forwarded rs/rt operands.
- Owns the HI/LO registers and models multi-cycle latency with a busy counter.
- Returns the mfhi/mflo read value to the EX result mux.
- Its busy output feeds the hazard unit's MDU stall term.

Parameters:
MULT_CYCLES, 5, cycles busy is held for mult/multu (>=1)
DIV_CYCLES, 10, cycles busy is held for div/divu (>=1)

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
start  input  1  decoder MDU-start: launch mult/multu/div/divu this cycle
mdu_sel  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 111 none
mf_sel  input  2  00 read HI, 01 read LO, 10/11 none
a  input  32  forwarded rs value
b  input  32  forwarded rt value
busy  output  1  operation in flight
hi  output  32  architectural HI
lo  output  32  architectural LO
mf_out  output  32  mfhi/mflo read value, combinational

Behaviour:
- Reset is asynchronous: hi=0, lo=0, busy=0, counter=0, pending results=0, state IDLE.
- States are IDLE and RUN.
- IDLE with start=1 and mdu_sel in 000..011:
  - Capture the result into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES, as the op requires.
  - Go to RUN; busy=1 from the next cycle.
- Pending results:
  - mult: signed 64-bit product, {hi,lo}.
  - multu: unsigned 64-bit product.
  - div: lo = signed quotient, hi = signed remainder. Remainder takes the sign of the dividend; quotient truncates toward zero.
  - divu: the unsigned equivalents.
- RUN: the counter decrements each cycle. On the edge where the counter reaches 1, pending values commit to hi/lo, busy drops to 0 and the state returns to IDLE. With start sampled at edge T, busy is high for exactly N cycles and hi/lo are valid after edge T+N.
- mthi/mtlo take effect only in IDLE with start=0: hi<=a or lo<=a at the next edge. No busy is asserted.
- While busy=1, start and mthi/mtlo are ignored. The hazard unit stalls on (busy|start) with any MDU instruction in D, so this case is a protocol violation and must not corrupt state.
- mf_out:
  - mf_sel=00 gives hi; 01 gives lo; otherwise 0.
  - It is a pure read of the architectural registers. Values written by mthi/mtlo at an edge are visible the cycle after.
  - While busy, mf_out returns the old hi/lo. The stall prevents consumption.
- Divide by zero (b=0, div/divu): the full busy latency still elapses. hi/lo are left unchanged at commit.
- Signed div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is wrap, not a trap.
- start=1 with mdu_sel 100/101/111: no multi-cycle op is launched. The mthi/mtlo rule applies.
- Reset asserted mid-RUN: immediate abort. The pending result is discarded and hi/lo return to 0.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- With the macro defined:
  - Adds input cancel (1 bit).
  - When cancel=1 in RUN, the state returns to IDLE at the next edge with busy=0. hi/lo keep their pre-start values and the pending result is discarded.
  - cancel in IDLE also suppresses a simultaneous start or mthi/mtlo.
  - Used for the exception flush.
- Without it: no cancel port, and a started operation always commits.

Decomposition:
- Package mdu_pkg:
  - MDU_SEL encodings: MULT, MULTU, DIV, DIVU, MTHI, MTLO, NONE.
  - MF_SEL encodings: HI, LO, NONE.
  - State encoding: IDLE, RUN.
- Counter width is derived from the larger of MULT_CYCLES and DIV_CYCLES.
- One natural sub-module: mdu_calc, purely combinational. It takes a, b and mdu_sel and produces the 64-bit {hi,lo} result plus a div_by_zero flag. The mdu_unit top holds the FSM, counter and registers.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3: busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. mf_sel=01 then gives 0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- div a=-7 (0xFFFFFFF9), b=2: busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with the same operands: lo=0x7FFFFFFC, hi=1.
- mthi a=0x1234 then mtlo a=0x5678 in IDLE: hi=0x1234 and lo=0x5678 one edge later, busy never asserted. An mthi issued while busy is ignored.
- div with b=0 after hi=0xAA, lo=0xBB: busy for 10 cycles, hi/lo stay 0xAA/0xBB.
- reset asserted at cycle 3 of a mult: busy=0, hi=lo=0 asynchronously, and no commit afterwards. Under MDU_CANCEL_EN, cancel at cycle 3 leaves hi/lo at their prior values.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and types for the MIPS EX-stage multiply/divide unit.
// Optional build macro used by the unit: MDU_CANCEL_EN.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101,
    MDU_NONE  = 3'b111
  } mdu_sel_e;

  typedef enum logic [1:0] {
    MF_HI   = 2'b00,
    MF_LO   = 2'b01,
    MF_NONE = 2'b10
  } mf_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // mult/multu/div/divu all have mdu_sel[2] clear
  function automatic logic is_md_op(input logic [2:0] sel);
    return (sel[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational mult/multu/div/divu datapath producing {hi,lo} and a divide-by-zero flag.
// One shared unsigned divider; signed divide is done on magnitudes with sign fix-up.
import mdu_pkg::*;

module mdu_calc (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_mdu_sel,
  output hilo_t       o_res,
  output logic        o_div_by_zero
);

  logic        w_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_divisor;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_b_zero;

  assign w_signed = (i_mdu_sel == MDU_MULT) || (i_mdu_sel == MDU_DIV);
  assign w_b_zero = (i_b == 32'd0);

  assign w_a_ext = w_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
  assign w_b_ext = w_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // 0x80000000 negates to itself, which is the correct magnitude as unsigned
  assign w_a_neg   = w_signed & i_a[31];
  assign w_b_neg   = w_signed & i_b[31];
  assign w_a_mag   = w_a_neg ? (32'd0 - i_a) : i_a;
  assign w_b_mag   = w_b_neg ? (32'd0 - i_b) : i_b;
  assign w_divisor = w_b_zero ? 32'd1 : w_b_mag;
  assign w_uq      = w_a_mag / w_divisor;
  assign w_ur      = w_a_mag % w_divisor;
  assign w_q       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
  assign w_r       = w_a_neg ? (32'd0 - w_ur) : w_ur;

  always_comb begin
    o_res         = '0;
    o_div_by_zero = 1'b0;
    case (i_mdu_sel)
      MDU_MULT, MDU_MULTU: o_res = w_prod;
      MDU_DIV, MDU_DIVU: begin
        o_res.hi      = w_r;
        o_res.lo      = w_q;
        o_div_by_zero = w_b_zero;
      end
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage MDU: owns HI/LO, holds busy for MULT_CYCLES/DIV_CYCLES then commits the result.
// Optional MDU_CANCEL_EN adds a cancel input that aborts a run or suppresses an IDLE request.
import mdu_pkg::*;

module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic [2:0]  mdu_sel,
  input  logic [1:0]  mf_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_out
);

  localparam int MAX_CYCLES = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  hilo_t         r_pend;
  logic          r_pend_dz;
  logic          r_busy;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  hilo_t         w_res;
  logic          w_dz;
  logic          w_cancel;
  logic          w_launch;

`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  assign w_launch = start && is_md_op(mdu_sel);

  mdu_calc u_calc (
    .i_a           (a),
    .i_b           (b),
    .i_mdu_sel     (mdu_sel),
    .o_res         (w_res),
    .o_div_by_zero (w_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_dz <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!w_cancel) begin
        if (w_launch) begin
          r_pend    <= w_res;
          r_pend_dz <= w_dz;
          r_cnt     <= mdu_sel[1] ? DIV_LOAD : MULT_LOAD;
          r_state   <= ST_RUN;
          r_busy    <= 1'b1;
        end else if (!start && (mdu_sel == MDU_MTHI)) begin
          r_hi <= a;
        end else if (!start && (mdu_sel == MDU_MTLO)) begin
          r_lo <= a;
        end
      end
    end else begin
      // Requests arriving while running are a stall-protocol violation and are dropped
      if (w_cancel) begin
        r_state   <= ST_IDLE;
        r_busy    <= 1'b0;
        r_cnt     <= '0;
        r_pend    <= '0;
        r_pend_dz <= 1'b0;
      end else if (r_cnt == CW'(1)) begin
        if (!r_pend_dz) begin
          r_hi <= r_pend.hi;
          r_lo <= r_pend.lo;
        end
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_comb begin
    mf_out = 32'd0;
    case (mf_sel)
      MF_HI:   mf_out = r_hi;
      MF_LO:   mf_out = r_lo;
      default: mf_out = 32'd0;
    endcase
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
